// File: rtl/id_pkg.sv
// Shared decode definitions for the MAS16 id_pipe_stage: opcodes, selType encodings and the decode bundle.
// The bundle's field widths follow ID_REG_AW / ID_IMM_W, which are also the stage's default parameters.
package id_pkg;

  localparam int ID_REG_AW = 2;
  localparam int ID_IMM_W  = 8;

  localparam logic [3:0] OP_ADC = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_SET = 4'hA;
  localparam logic [3:0] OP_LTC = 4'hD;
  localparam logic [3:0] OP_CBZ = 4'hE;
  localparam logic [3:0] OP_JMP = 4'hF;

  typedef enum logic [1:0] {
    SEL_ARITH = 2'd0,
    SEL_LOGIC = 2'd1,
    SEL_MEM   = 2'd2,
    SEL_CTRL  = 2'd3
  } sel_type_e;

  typedef struct packed {
    logic [ID_REG_AW-1:0] rd;
    logic [ID_REG_AW-1:0] ra;
    logic [ID_REG_AW-1:0] rb;
    logic [ID_IMM_W-1:0]  c;
    sel_type_e            sel_type;
    logic [1:0]           sel_op;
    logic                 sel_b;
    logic                 jsel;
    logic                 memwen;
    logic                 rfen;
  } decode_t;

  // Second operand comes from the immediate rather than rb for these opcodes.
  function automatic logic uses_imm(input logic [3:0] op);
    return op inside {OP_ADC, OP_LD, OP_ST, OP_SET, OP_LTC, OP_CBZ, OP_JMP};
  endfunction

  function automatic logic writes_rf(input logic [3:0] op);
    return !(op inside {OP_ST, OP_CBZ, OP_JMP});
  endfunction

  function automatic logic reads_ra(input logic [3:0] op);
    return !(op inside {OP_SET, OP_JMP});
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register, set at issue and cleared at writeback.
// A set and a clear of the same register in one cycle leave the bit set.
module id_scoreboard #(
  parameter int REG_AW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_AW-1:0]    set_idx,
  input  logic                 clr_en,
  input  logic [REG_AW-1:0]    clr_idx,
  output logic [2**REG_AW-1:0] busy
);

  localparam int NREG = 2**REG_AW;

  logic [NREG-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    for (int i = 0; i < NREG; i++) begin
      if (set_en && (set_idx == REG_AW'(i))) begin
        busy_next[i] = 1'b1;
      end else if (clr_en && (clr_idx == REG_AW'(i))) begin
        busy_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/id_pipe_stage.sv
// Registered MAS16 instruction-decode stage with valid/ready handshake and flush.
// Define ID_SCOREBOARD_EN to build the RAW/WAW scoreboard; otherwise the wb_* ports are ignored.
module id_pipe_stage
  import id_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_AW  = ID_REG_AW,
  parameter int IMM_W   = ID_IMM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  rd,
  output logic [REG_AW-1:0]  ra,
  output logic [REG_AW-1:0]  rb,
  output logic [IMM_W-1:0]   c,
  output logic [1:0]         selType,
  output logic [1:0]         selOp,
  output logic               selB,
  output logic               jsel,
  output logic               memwen,
  output logic               rfen,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_rd,
  inout  wire                dvdd,
  inout  wire                dgnd
);

  localparam int RD_LSB = INSTR_W - OPC_W - REG_AW;
  localparam int RA_LSB = RD_LSB - REG_AW;

  logic [3:0] op;
  decode_t    dec;
  decode_t    held;
  logic       held_valid;
  logic       hazard;
  logic       accept;
  logic       issue;

  always_comb begin
    op           = instr[INSTR_W-1 -: 4];
    dec          = '0;
    dec.rd       = instr[RD_LSB +: REG_AW];
    dec.ra       = instr[RA_LSB +: REG_AW];
    dec.rb       = instr[REG_AW-1:0];
    dec.c        = instr[IMM_W-1:0];
    dec.sel_type = sel_type_e'(op[3:2]);
    dec.sel_op   = op[1:0];
    dec.sel_b    = uses_imm(op);
    dec.memwen   = (op == OP_ST);
    dec.rfen     = writes_rf(op);
    dec.jsel     = (op == OP_JMP);
  end

`ifdef ID_SCOREBOARD_EN
  logic [2**REG_AW-1:0] sb_busy;
  logic [2**REG_AW-1:0] busy;

  id_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue && held.rfen),
    .set_idx (held.rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .busy    (sb_busy)
  );

  // The held, not-yet-issued destination counts as busy so WAW/RAW cannot slip past it.
  always_comb begin
    busy = sb_busy;
    if (held_valid && held.rfen) begin
      busy[held.rd] = 1'b1;
    end
    hazard = (reads_ra(op) && busy[dec.ra])
          || (!dec.sel_b && busy[dec.rb])
          || (dec.rfen && busy[dec.rd]);
  end
`else
  logic unused_wb;
  assign hazard    = 1'b0;
  assign unused_wb = &{1'b0, wb_valid, wb_rd};
`endif

  logic unused_supply;
  assign unused_supply = &{1'b0, dvdd, dgnd};

  assign in_ready = !rst && !flush && !hazard && (!held_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign issue    = held_valid && out_ready && !flush;

  // Accept can replace an instruction issuing in the same cycle; flush always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid <= 1'b0;
      held       <= '0;
    end else if (flush) begin
      held_valid <= 1'b0;
    end else if (accept) begin
      held_valid <= 1'b1;
      held       <= dec;
    end else if (issue) begin
      held_valid <= 1'b0;
    end
  end

  assign out_valid = held_valid;
  assign rd        = held.rd;
  assign ra        = held.ra;
  assign rb        = held.rb;
  assign c         = held.c;
  assign selType   = held.sel_type;
  assign selOp     = held.sel_op;
  assign selB      = held.sel_b;
  assign jsel      = held.jsel;
  assign memwen    = held.memwen;
  assign rfen      = held.rfen;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed plus random bench for id_pipe_stage against a cycle-level reference model.
// Scoreboard expectations are only modelled when ID_SCOREBOARD_EN is defined.
module tb_id_pipe_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, wb_valid;
  logic [15:0] instr;
  logic [1:0]  rd, ra, rb, wb_rd, selType, selOp;
  logic [7:0]  c;
  logic        selB, jsel, memwen, rfen;
  logic [21:0] dut_fields;
  wire         dvdd;
  wire         dgnd;

  assign dvdd = 1'b1;
  assign dgnd = 1'b0;
  assign dut_fields = {rd, ra, rb, c, selType, selOp, selB, jsel, memwen, rfen};

  int n_assert = 0;
  int n_fail   = 0;

  bit          m_valid;
  logic [15:0] m_instr;
  logic [21:0] m_fields;
`ifdef ID_SCOREBOARD_EN
  bit          pending [4];
`endif

  id_pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .rd(rd), .ra(ra), .rb(rb), .c(c), .selType(selType), .selOp(selOp),
    .selB(selB), .jsel(jsel), .memwen(memwen), .rfen(rfen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .dvdd(dvdd), .dgnd(dgnd)
  );

  always #5 clk = ~clk;

  function automatic int op_of(input logic [15:0] w); return int'(w) / 4096; endfunction
  function automatic int rd_of(input logic [15:0] w); return (int'(w) / 1024) % 4; endfunction
  function automatic int ra_of(input logic [15:0] w); return (int'(w) / 256) % 4; endfunction
  function automatic int rb_of(input logic [15:0] w); return int'(w) % 4; endfunction
  function automatic bit imm_op(input int op); return op inside {0, 8, 9, 10, 13, 14, 15}; endfunction
  function automatic bit wr_op(input int op); return !(op inside {9, 14, 15}); endfunction

  function automatic logic [21:0] decode(input logic [15:0] w);
    int op = op_of(w);
    return {2'(rd_of(w)), 2'(ra_of(w)), 2'(rb_of(w)), 8'(int'(w) % 256),
            2'(op / 4), 2'(op % 4), imm_op(op), (op == 15), (op == 9), wr_op(op)};
  endfunction

  function automatic bit exp_ready(input bit r, input bit f, input bit ordy, input logic [15:0] w);
    bit hz = 1'b0;
`ifdef ID_SCOREBOARD_EN
    bit busy [4];
    int op = op_of(w);
    busy = pending;
    if (m_valid && wr_op(op_of(m_instr))) busy[rd_of(m_instr)] = 1'b1;
    hz = (!(op inside {10, 15}) && busy[ra_of(w)]) || (!imm_op(op) && busy[rb_of(w)])
      || (wr_op(op) && busy[rd_of(w)]);
`endif
    return !r && !f && !hz && (!m_valid || ordy);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check, then advance the model across the rising edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [15:0] w, input bit f,
                               input bit ordy, input bit wbv, input logic [1:0] wbr);
    bit er, acc, iss;
    rst = r; in_valid = v; instr = w; flush = f; out_ready = ordy; wb_valid = wbv; wb_rd = wbr;
    #1;
    er = exp_ready(r, f, ordy, w);
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("fields", 32'(dut_fields), 32'(m_fields));
    checkOutput("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_instr = '0; m_fields = '0;
`ifdef ID_SCOREBOARD_EN
      foreach (pending[i]) pending[i] = 1'b0;
`endif
    end else begin
      acc = v && er;
      iss = m_valid && ordy && !f;
`ifdef ID_SCOREBOARD_EN
      if (wbv) pending[wbr] = 1'b0;
      if (iss && wr_op(op_of(m_instr))) pending[rd_of(m_instr)] = 1'b1;
`endif
      if (f) m_valid = 1'b0;
      else if (acc) begin m_valid = 1'b1; m_instr = w; m_fields = decode(w); end
      else if (iss) m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    m_valid = 1'b0; m_instr = '0; m_fields = '0;
`ifdef ID_SCOREBOARD_EN
    foreach (pending[i]) pending[i] = 1'b0;
`endif
    @(negedge clk);

    // Reset, with an instruction offered while rst is high
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 2'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_fields", 32'(dut_fields), 32'd0);

    // Back-to-back independent instructions
    applyStimulus(1'b0, 1'b1, 16'h0405, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 16'h1603, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0);

    // Fixed decode of 0x1603 from an empty stage, then flush with an offer
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 16'h1603, 1'b0, 1'b0, 1'b0, 2'd0);
    checkOutput("dec1603_rd", 32'(rd), 32'd1);
    checkOutput("dec1603_ra", 32'(ra), 32'd2);
    checkOutput("dec1603_rb", 32'(rb), 32'd3);
    checkOutput("dec1603_selB", 32'(selB), 32'd0);
    checkOutput("dec1603_rfen", 32'(rfen), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h2900, 1'b1, 1'b1, 1'b0, 2'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h2900, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0);

    // RAW on r1, released by writeback
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 16'h1400, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'h2900, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 16'h2900, 1'b0, 1'b1, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b1, 16'h2900, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0);

    // Issue and writeback of r2 in the same cycle
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 16'h2800, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd2);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 1'b1, 2'd2);
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 1'b0, 2'd0);

    // Store held for three cycles, then issued
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 16'h9123, 1'b0, 1'b0, 1'b0, 2'd0);
    checkOutput("st_memwen", 32'(memwen), 32'd1);
    checkOutput("st_rfen", 32'(rfen), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b0, 2'd0);

    // Reset during a RAW stall, then the same instruction without writeback
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 16'h1400, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 16'h2900, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 16'h2900, 1'b0, 1'b1, 1'b0, 2'd0);
    checkOutput("rst_stall_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h2900, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 16'($urandom),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
